// File: rtl/count_rate_pkg.sv
// Shared encodings and the rate-table helper for count_rate_gen and its limit LUT.
package count_rate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_t;

  // Entry k is 2**(nb_counter-base_shift-k)-1. This is built in 64 bits, and the caller truncates it to the counter width.
  function automatic logic [63:0] table_entry(input int unsigned nb_counter,
                                              input int unsigned base_shift,
                                              input int unsigned k);
    return (64'd1 << (nb_counter - base_shift - k)) - 64'd1;
  endfunction

endpackage

// File: rtl/count_limit_lut.sv
// Combinational rate-select table: maps a select index onto its power-of-two-minus-one terminal count.
module count_limit_lut
  import count_rate_pkg::*;
#(
  parameter int unsigned NB_COUNTER = 32,
  parameter int unsigned NB_SEL     = 2,
  parameter int unsigned BASE_SHIFT = 10
) (
  input  logic [NB_SEL-1:0]     sel,
  output logic [NB_COUNTER-1:0] limit
);

  localparam int unsigned ENTRIES = 2 ** NB_SEL;

  logic [NB_COUNTER-1:0] entries [ENTRIES];

  for (genvar k = 0; k < ENTRIES; k++) begin : g_entry
    assign entries[k] = NB_COUNTER'(table_entry(NB_COUNTER, BASE_SHIFT, k));
  end

  assign limit = entries[sel];

endmodule

// File: rtl/count_rate_gen.sv
// Programmable rate/tick generator with periodic and one-shot modes.
// Define COUNT_RATE_LOAD_EN to add an externally loadable limit (i_use_limit/i_limit).
module count_rate_gen
  import count_rate_pkg::*;
#(
  parameter int unsigned NB_COUNTER = 32,
  parameter int unsigned NB_SEL     = 2,
  parameter int unsigned BASE_SHIFT = 10,
  parameter int unsigned NB_TICKS   = 8
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [NB_SEL-1:0]     i_sel,
  input  logic                  i_mode,
  input  logic                  i_start,
  input  logic                  i_clear,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [NB_TICKS-1:0]   o_ticks
`ifdef COUNT_RATE_LOAD_EN
  ,
  input  logic                  i_use_limit,
  input  logic [NB_COUNTER-1:0] i_limit
`endif
);

  state_t                state, state_next;
  mode_t                 mode, mode_next;
  logic [NB_COUNTER-1:0] count, count_next;
  logic [NB_COUNTER-1:0] limit, limit_next;
  logic [NB_COUNTER-1:0] table_limit;
  logic [NB_COUNTER-1:0] limit_sel;
  logic [NB_TICKS-1:0]   ticks, ticks_next;
  logic                  valid, valid_next;
  logic                  busy, busy_next;
  logic                  done, done_next;

  count_limit_lut #(
    .NB_COUNTER(NB_COUNTER),
    .NB_SEL    (NB_SEL),
    .BASE_SHIFT(BASE_SHIFT)
  ) u_lut (
    .sel  (i_sel),
    .limit(table_limit)
  );

`ifdef COUNT_RATE_LOAD_EN
  assign limit_sel = i_use_limit ? i_limit : table_limit;
`else
  assign limit_sel = table_limit;
`endif

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      mode  <= MODE_PERIODIC;
      count <= '0;
      limit <= '0;
      ticks <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      mode  <= mode_next;
      count <= count_next;
      limit <= limit_next;
      ticks <= ticks_next;
      valid <= valid_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // The limit changes only while the counter is zero, so an equality compare is enough to detect the terminal count.
  always_comb begin
    state_next = state;
    mode_next  = mode;
    count_next = count;
    limit_next = limit;
    ticks_next = ticks;
    valid_next = 1'b0;
    done_next  = done;

    if (i_clear) begin
      state_next = IDLE;
      count_next = '0;
      ticks_next = '0;
      done_next  = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state_next = RUN;
            count_next = '0;
            limit_next = limit_sel;
            mode_next  = mode_t'(i_mode);
            done_next  = 1'b0;
          end
        end
        RUN: begin
          if (i_enable) begin
            if (count == limit) begin
              count_next = '0;
              valid_next = 1'b1;
              ticks_next = ticks + NB_TICKS'(1);
              if (mode == MODE_ONESHOT) begin
                state_next = DONE;
                done_next  = 1'b1;
              end else begin
                limit_next = limit_sel;
              end
            end else begin
              count_next = count + NB_COUNTER'(1);
            end
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end

    busy_next = (state_next == RUN);
  end

  assign o_valid = valid;
  assign o_busy  = busy;
  assign o_done  = done;
  assign o_ticks = ticks;

endmodule

// File: tb/tb_count_rate_gen.sv
// Scoreboard bench for count_rate_gen (NB_COUNTER=8, NB_SEL=2, BASE_SHIFT=4; table 15,7,3,1).
module tb_count_rate_gen;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_enable = 1'b0;
  logic [1:0] i_sel = '0;
  logic       i_mode = 1'b0;
  logic       i_start = 1'b0;
  logic       i_clear = 1'b0;
  logic       o_valid, o_busy, o_done;
  logic [7:0] o_ticks;
`ifdef COUNT_RATE_LOAD_EN
  logic       i_use_limit = 1'b0;
  logic [7:0] i_limit = '0;
`endif

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] ticks;
  } exp_t;

  exp_t exp_q[$];

  count_rate_gen #(
    .NB_COUNTER(8),
    .NB_SEL    (2),
    .BASE_SHIFT(4),
    .NB_TICKS  (8)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .i_sel   (i_sel),
    .i_mode  (i_mode),
    .i_start (i_start),
    .i_clear (i_clear),
    .o_valid (o_valid),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_ticks (o_ticks)
`ifdef COUNT_RATE_LOAD_EN
    ,
    .i_use_limit(i_use_limit),
    .i_limit    (i_limit)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Returns at the negedge after the accepting edge; cyc then equals that edge's index.
  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clock);
    i_start = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    @(negedge clock);
    i_clear = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) @(negedge clock);
    compared++;
    if ({o_valid, o_busy, o_done, o_ticks} !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_init: got v%b b%b d%b t%0d, expected all 0", o_valid, o_busy, o_done, o_ticks);
    end
    i_reset = 1'b1;
    i_sel = 2'd0; i_mode = 1'b0; i_enable = 1'b1;
    pulse_start();
    repeat (3) @(negedge clock);
    compared++;
    if (o_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_run_busy: got %b, expected 1", o_busy);
    end
    #2 i_reset = 1'b0;
    #1;
    compared++;
    if ({o_valid, o_busy, o_done, o_ticks} !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_async: got v%b b%b d%b t%0d, expected all 0", o_valid, o_busy, o_done, o_ticks);
    end
    @(negedge clock);
    i_reset = 1'b1;
    repeat (5) @(negedge clock);
    compared++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: got busy %b valid %b, expected 0 0", o_busy, o_valid);
    end
  endtask

  task automatic test_periodic();
    exp_t e;
    int   s;
    i_sel = 2'd2; i_mode = 1'b0; i_enable = 1'b1;
    pulse_start();
    s = cyc;
    for (int k = 1; k <= 3; k++) exp_q.push_back('{s + 4 * k, 8'(k)});
    repeat (13) begin
      @(negedge clock);
      if (o_valid) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL periodic_extra: got strobe at cycle %0d, expected none", cyc - s);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e.cyc || o_ticks !== e.ticks) begin
            mismatched++;
            $display("FAIL periodic_strobe: got cycle %0d ticks %0d, expected cycle %0d ticks %0d",
                     cyc - s, o_ticks, e.cyc - s, e.ticks);
          end
        end
      end
    end
    compared++;
    if (exp_q.size() != 0 || o_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL periodic_end: got %0d outstanding busy %b, expected 0 outstanding busy 1", exp_q.size(), o_busy);
    end
    exp_q.delete();
    pulse_clear();
    compared++;
    if (o_busy !== 1'b0 || o_ticks !== 8'd0) begin
      mismatched++;
      $display("FAIL periodic_clear: got busy %b ticks %0d, expected 0 0", o_busy, o_ticks);
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    int   s;
    i_sel = 2'd1; i_mode = 1'b1; i_enable = 1'b1;
    for (int run = 1; run <= 2; run++) begin
      pulse_start();
      s = cyc;
      compared++;
      if (o_done !== 1'b0 || o_busy !== 1'b1) begin
        mismatched++;
        $display("FAIL oneshot_start%0d: got done %b busy %b, expected 0 1", run, o_done, o_busy);
      end
      exp_q.push_back('{s + 8, 8'(run)});
      i_mode = 1'b0;  // must be ignored until the next start
      repeat (16) begin
        @(negedge clock);
        if (o_valid) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL oneshot_extra: got strobe at cycle %0d, expected none", cyc - s);
          end else begin
            e = exp_q.pop_front();
            if (cyc !== e.cyc || o_ticks !== e.ticks) begin
              mismatched++;
              $display("FAIL oneshot_strobe: got cycle %0d ticks %0d, expected cycle %0d ticks %0d",
                       cyc - s, o_ticks, e.cyc - s, e.ticks);
            end
          end
        end
      end
      compared++;
      if (exp_q.size() != 0 || o_done !== 1'b1 || o_busy !== 1'b0) begin
        mismatched++;
        $display("FAIL oneshot_done%0d: got %0d outstanding done %b busy %b, expected 0 1 0",
                 run, exp_q.size(), o_done, o_busy);
      end
      exp_q.delete();
      i_mode = 1'b1;
    end
    pulse_clear();
    compared++;
    if (o_done !== 1'b0) begin
      mismatched++;
      $display("FAIL oneshot_clear: got done %b, expected 0", o_done);
    end
  endtask

  task automatic test_reselect_gating();
    exp_t e;
    int   s;
    i_sel = 2'd0; i_mode = 1'b0; i_enable = 1'b1;
    pulse_start();
    s = cyc;
    // 5 enabled + 3 gated + 11 enabled edges gives the 16-cycle first period, and then L=1 periods follow.
    exp_q.push_back('{s + 19, 8'd1});
    exp_q.push_back('{s + 21, 8'd2});
    exp_q.push_back('{s + 23, 8'd3});
    exp_q.push_back('{s + 25, 8'd4});
    i_sel = 2'd0;
    for (int r = 1; r <= 26; r++) begin
      if (r == 6) begin i_sel = 2'd3; i_enable = 1'b0; end
      if (r == 9) i_enable = 1'b1;
      @(negedge clock);
      if (o_valid) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL reselect_extra: got strobe at cycle %0d, expected none", cyc - s);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e.cyc || o_ticks !== e.ticks) begin
            mismatched++;
            $display("FAIL reselect_strobe: got cycle %0d ticks %0d, expected cycle %0d ticks %0d",
                     cyc - s, o_ticks, e.cyc - s, e.ticks);
          end
        end
      end
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL reselect_missing: got %0d outstanding, expected 0", exp_q.size());
    end
    exp_q.delete();
    pulse_clear();
  endtask

  task automatic test_wrap_clear();
    exp_t e;
    int   s;
    i_sel = 2'd3; i_mode = 1'b0; i_enable = 1'b1;
    pulse_start();
    s = cyc;
    for (int k = 1; k <= 513; k++) exp_q.push_back('{s + 2 * k, 8'(k % 256)});
    repeat (1027) begin
      @(negedge clock);
      if (o_valid) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL wrap_extra: got strobe at cycle %0d, expected none", cyc - s);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e.cyc || o_ticks !== e.ticks) begin
            mismatched++;
            $display("FAIL wrap_strobe: got cycle %0d ticks %0d, expected cycle %0d ticks %0d",
                     cyc - s, o_ticks, e.cyc - s, e.ticks);
          end
        end
      end
    end
    compared++;
    if (exp_q.size() != 0 || o_ticks !== 8'd1) begin
      mismatched++;
      $display("FAIL wrap_end: got %0d outstanding ticks %0d, expected 0 outstanding ticks 1", exp_q.size(), o_ticks);
    end
    exp_q.delete();
    // The edge that follows (s+1028) is a terminal count, and the clear must take priority over it.
    pulse_clear();
    compared++;
    if (o_valid !== 1'b0 || o_ticks !== 8'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_terminal: got v%b t%0d b%b d%b, expected 0 0 0 0", o_valid, o_ticks, o_busy, o_done);
    end
    repeat (4) @(negedge clock);
    compared++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_idle: got busy %b valid %b, expected 0 0", o_busy, o_valid);
    end
  endtask

`ifdef COUNT_RATE_LOAD_EN
  task automatic test_load_limit();
    exp_t e;
    int   s;
    i_use_limit = 1'b1; i_mode = 1'b0; i_enable = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      i_limit = (pass == 0) ? 8'd0 : 8'd5;
      pulse_start();
      s = cyc;
      for (int k = 1; k <= 4; k++) exp_q.push_back('{s + (int'(i_limit) + 1) * k, 8'(k)});
      repeat ((int'(i_limit) + 1) * 4) begin
        @(negedge clock);
        if (o_valid) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL load_extra: got strobe at cycle %0d, expected none", cyc - s);
          end else begin
            e = exp_q.pop_front();
            if (cyc !== e.cyc || o_ticks !== e.ticks) begin
              mismatched++;
              $display("FAIL load_strobe: got cycle %0d ticks %0d, expected cycle %0d ticks %0d",
                       cyc - s, o_ticks, e.cyc - s, e.ticks);
            end
          end
        end
      end
      compared++;
      if (exp_q.size() != 0) begin
        mismatched++;
        $display("FAIL load_missing: got %0d outstanding, expected 0", exp_q.size());
      end
      exp_q.delete();
      pulse_clear();
    end
    i_use_limit = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_reselect_gating();
    test_wrap_clear();
`ifdef COUNT_RATE_LOAD_EN
    test_load_limit();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
